// File: rtl/score_display_if.sv
// Scoreboard display bus: score/load request in, conversion status,
// latched BCD digits and the scanned segment/digit-enable outputs.
interface score_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   digit_sel;

    // Scoring-logic side
    modport master (
        output value, load,
        input  busy, done, overflow, bcd, seg, digit_sel
    );

    // Display-driver side
    modport slave (
        input  value, load,
        output busy, done, overflow, bcd, seg, digit_sel
    );
endinterface

// File: rtl/score_display.sv
// score_display: binary score -> DIGITS BCD digits (sequential double-dabble),
// latched and time-multiplexed onto a shared seven-segment bus.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_display #(
    parameter int WIDTH    = 10,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic           clk,
    input  logic           nrst,
    score_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int LIMIT = pow10(DIGITS);

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h67;
            default: return 8'h00;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [BW-1:0]   adj;
    logic [31:0]     value_ext;
    logic [3:0]      cur_digit;
    logic            blank;

    assign value_ext = 32'(bus.value);

    // Add-3 correction for every scratch nibble that is 5 or more
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                              ? scratch_q[4*gi +: 4] + 4'd3
                              : scratch_q[4*gi +: 4];
    end

    // State and datapath registers; async reset returns everything to idle/blank-free zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    // Next-state logic: the WIDTH-th shift happens when the count is 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    // Conversion datapath: capture, shift-and-add-3, latch (saturating to all nines)
    always_comb begin
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d     = bus.value;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    ovf_d     = (value_ext >= 32'(LIMIT));
                end
            end
            SHIFT: begin
                // Bits leaving the top nibble are dropped; they only matter on overflow
                {scratch_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CW'(1);
            end
            LATCH: begin
                bcd_d      = ovf_q ? {DIGITS{4'h9}} : scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan prescaler and digit index; free-running, never stalled by conversions
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a zero digit when all more-significant digits are zero too; digit 0 always shows
    always_comb begin
        blank = (idx_q != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_q) && bcd_q[4*k +: 4] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign cur_digit     = bcd_q[4*int'(idx_q) +: 4];
    assign bus.seg       = blank ? 8'h00 : seg_decode(cur_digit);
    assign bus.digit_sel = DIGITS'(1) << idx_q;
    assign bus.bcd       = bcd_q;
    assign bus.overflow  = overflow_q;
    assign bus.done      = done_q;
endmodule

// File: doc/score_display.md
# score_display

Parametrised score-to-seven-segment driver for the game's scoreboard. Converts a WIDTH-bit binary score into DIGITS BCD digits with a sequential shift-and-add-3 (double-dabble) engine, holds the result, and time-multiplexes the digits onto one shared segment bus with one-hot digit enables. Sits between the scoring logic and the board's seven-segment displays. Supersedes fixed two-digit combinational decoding with arbitrary width and digit count, saturation and scan multiplexing.

## Interface
- WIDTH, 10, binary score width; legal 1..20
- DIGITS, 3, number of decimal digits displayed; legal 1..6
- SCAN_DIV, 1000, clock cycles each digit is enabled before the scan advances; legal >= 1
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- value  in  WIDTH  binary score, sampled only when a load is accepted
- load  in  1  conversion request, accepted only in IDLE
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when new digits are latched
- overflow  out  1  value at last accepted load was >= 10^DIGITS
- bcd  out  4*DIGITS  latched digits; nibble 0 = least significant
- seg  out  8  segments of the scanned digit; bit0=a..bit6=g, bit7 always 0, active high
- digit_sel  out  DIGITS  one-hot digit enable; bit 0 = least significant digit

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: load=1 at an edge captures value into the binary shift register, clears the DIGITS-nibble scratch, sets shift count to WIDTH, records ovf = (value >= 10^DIGITS), and moves to SHIFT.
- SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch, binary} shifts left by 1; bits shifted out of the top nibble are discarded. After the WIDTH-th shift, move to LATCH.
- LATCH: bcd <= scratch, or all nibbles 4'h9 if ovf; overflow <= ovf; done=1 for this edge's output cycle; return to IDLE.
- load in SHIFT or LATCH is ignored; not queued.
- Segment map: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x67; nibble 10..15 (unreachable) = 0x00.
- Scan: prescaler counts 0..SCAN_DIV-1; on wrap, digit index advances 0..DIGITS-1 and wraps to 0. digit_sel = 1 << index; seg = decode of bcd nibble[index], combinational from registers.
- bcd/seg change only at LATCH; the scan never stalls during conversion, so old digits remain displayed until LATCH.

## Timing
- Reset (nrst low, async): state IDLE, busy 0, done 0, overflow 0, bcd 0, prescaler 0, index 0, digit_sel = 1, seg = 0x3F.
- Latency: load accepted at edge E0; busy high from E0 through edge E0+WIDTH+1; bcd, overflow updated and done high in the cycle after E0+WIDTH+1; total WIDTH+1 cycles from accept to done.
- load high in the same cycle done is high is accepted (FSM is IDLE); back-to-back conversions every WIDTH+2 cycles.
- Reset asserted mid-conversion aborts; outputs return to reset values immediately; no done pulse.
- SCAN_DIV=1: index advances every cycle.
- DIGITS=1: digit_sel constant 1.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when the scanned digit is zero and every more-significant digit is zero, seg = 0x00 (digit_sel still asserted); digit 0 is never blanked, so value 0 shows a single "0". Blanking is evaluated on latched bcd.
- Undefined: all digits always shown, including leading zeros (e.g. "007").

## Test plan
- Reset then idle, defaults -> digit_sel=3'b001, seg=0x3F, bcd=0, busy=0, overflow=0.
- load value=10'd987, defaults -> busy 11 cycles, done one cycle after, bcd=12'h987, overflow=0; scan with SCAN_DIV=2 shows 0x7F, 0x67 for digits 1 and 2 in order 0x07, 0x7F, 0x67, wrapping.
- load value=10'd1023, DIGITS=3 -> bcd=12'h999, overflow=1; next load 10'd5 -> bcd=12'h005, overflow=0.
- load held high continuously with changing value -> accepted only at IDLE edges, one done per WIDTH+2 cycles, each bcd matching the value sampled at its accept edge.
- nrst pulsed low 4 cycles after a load of 10'd512 -> no done, bcd=0, busy=0; then load 10'd42 -> bcd=12'h042.
- LEADING_ZERO_BLANK_EN, load 10'd7 -> digits 2,1 seg=0x00, digit 0 seg=0x07; load 10'd0 -> only digit 0 shows 0x3F; without macro digits show 0x3F,0x3F,0x07.
